// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder for the core's MEM stage.
// The lower half of the word-address space is synchronous RAM. The upper half
// is a small I/O window holding a GPIO output register, a synchronized GPIO
// input, a free-running cycle counter and a compare/interrupt unit.
// Read data is registered, giving one cycle of latency.
// A simultaneous read and write to the same location returns the old value.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 128,
  parameter int GPIO_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data,
  input  logic                  wren,
  input  logic                  rden,
  output logic [31:0]           q,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq
);

  localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
  localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  // RAM contents are deliberately left out of reset.
  logic [31:0] ram [RAM_DEPTH];

  logic [GPIO_WIDTH-1:0] gpio_out_r;
  logic [GPIO_WIDTH-1:0] sync1_r;
  logic [GPIO_WIDTH-1:0] sync2_r;
  logic [31:0]           count_r;
  logic [31:0]           compare_r;
  logic [31:0]           q_r;
  logic                  irq_r;
  logic                  ovf_r;

  logic                  is_io_s;
  logic [2:0]            io_off_s;
  logic [ADDR_WIDTH-2:0] ram_idx_s;
  logic                  wr_ram_s;
  logic                  wr_gpio_s;
  logic                  wr_count_s;
  logic                  wr_compare_s;
  logic                  wr_status_s;
  logic                  match_s;
  logic                  wrap_s;
  logic                  irq_next_s;
  logic                  ovf_next_s;
  logic [31:0]           count_next_s;
  logic [31:0]           rd_data_s;

  // The top address bit selects the I/O window.
  // Inside the window, only the low three bits matter, so the window aliases.
  assign is_io_s   = address[ADDR_WIDTH-1];
  assign io_off_s  = address[2:0];
  assign ram_idx_s = address[ADDR_WIDTH-2:0];

  // Decode the write strobe into one enable per writable target.
  always_comb begin
    wr_ram_s     = 1'b0;
    wr_gpio_s    = 1'b0;
    wr_count_s   = 1'b0;
    wr_compare_s = 1'b0;
    wr_status_s  = 1'b0;
    if (wren) begin
      if (is_io_s) begin
        case (io_off_s)
          OFF_GPIO_OUT: wr_gpio_s    = 1'b1;
          OFF_COUNT:    wr_count_s   = 1'b1;
          OFF_COMPARE:  wr_compare_s = 1'b1;
          OFF_STATUS:   wr_status_s  = 1'b1;
          default:      wr_gpio_s    = 1'b0;
        endcase
      end else begin
        wr_ram_s = 1'b1;
      end
    end else begin
      wr_ram_s = 1'b0;
    end
  end

  // Compute the next counter value and the sticky status bits.
  // A counter write wins over the increment.
  // A new compare match or a wrap wins over a software clear.
  always_comb begin
    match_s      = (count_r == compare_r) && (compare_r != 32'd0);
    wrap_s       = (count_r == 32'hFFFF_FFFF) && !wr_count_s;
    count_next_s = count_r + 32'd1;
    if (wr_count_s) begin
      count_next_s = 32'd0;
    end else begin
      count_next_s = count_r + 32'd1;
    end
    irq_next_s = match_s | (irq_r & ~(wr_status_s & data[0]));
    ovf_next_s = wrap_s  | (ovf_r & ~(wr_status_s & data[1]));
  end

  // Read multiplexer over RAM and the I/O registers.
  // The values it sees are the ones before the current edge.
  always_comb begin
    rd_data_s = 32'd0;
    if (is_io_s) begin
      case (io_off_s)
        OFF_GPIO_OUT: rd_data_s = 32'(gpio_out_r);
        OFF_GPIO_IN:  rd_data_s = 32'(sync2_r);
        OFF_COUNT:    rd_data_s = count_r;
        OFF_COMPARE:  rd_data_s = compare_r;
        OFF_STATUS:   rd_data_s = {30'd0, ovf_r, irq_r};
        default:      rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = ram[ram_idx_s];
    end
  end

  // RAM write port (no reset on storage).
  always_ff @(posedge clk) begin
    if (wr_ram_s) begin
      ram[ram_idx_s] <= data;
    end
  end

  // Registered read data; holds its value while rden is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= 32'd0;
    end else if (rden) begin
      q_r <= rd_data_s;
    end
  end

  // GPIO output register, changed only by a write to its offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out_r <= '0;
    end else if (wr_gpio_s) begin
      gpio_out_r <= data[GPIO_WIDTH-1:0];
    end
  end

  // Two-flop synchronizer for the asynchronous GPIO inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
    end
  end

  // Free-running cycle counter and the compare register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r   <= 32'd0;
      compare_r <= 32'd0;
    end else begin
      count_r <= count_next_s;
      if (wr_compare_s) begin
        compare_r <= data;
      end
    end
  end

  // Sticky status bits: the compare-match interrupt and the counter overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      irq_r <= irq_next_s;
      ovf_r <= ovf_next_s;
    end
  end

  assign q        = q_r;
  assign gpio_out = gpio_out_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenario tasks plus a randomized
// run, all compared against a behavioural model of the memory map.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [7:0]  address;
  logic [31:0] data;
  logic        wren;
  logic        rden;
  logic [31:0] q;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        irq;

  int total;
  int bad;

  // Behavioural model state.
  logic [31:0] mem_m [int];
  logic [31:0] q_m;
  bit          q_known;
  logic [31:0] gpio_m;
  longint      cnt_m;
  logic [31:0] cmp_m;
  bit          irq_m;
  bit          ovf_m;
  logic [31:0] hist_m [$];   // gpio_in samples from the last two edges

  data_mem_responder #(.ADDR_WIDTH(8), .RAM_DEPTH(128), .GPIO_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .address(address), .data(data), .wren(wren),
    .rden(rden), .q(q), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q_m = 32'd0; q_known = 1'b1; gpio_m = 32'd0; cnt_m = 0; cmp_m = 32'd0;
    irq_m = 1'b0; ovf_m = 1'b0;
    hist_m = {32'd0, 32'd0};
  endtask

  // Advance the model by one rising edge.
  task automatic model_step(input logic w, input logic r, input logic [7:0] a,
                            input logic [31:0] d, input logic [31:0] gin);
    bit     io;
    int     off;
    bit     hit;
    bit     cnt_wr;
    bit     st_wr;
    longint nxt;
    io = a[7];
    off = int'(a[2:0]);
    if (r) begin
      q_known = 1'b1;
      if (!io) begin
        if (mem_m.exists(int'(a[6:0]))) q_m = mem_m[int'(a[6:0])];
        else q_known = 1'b0;
      end else begin
        case (off)
          0: q_m = gpio_m;
          1: q_m = hist_m[0];
          2: q_m = 32'(cnt_m);
          3: q_m = cmp_m;
          4: q_m = {30'd0, ovf_m, irq_m};
          default: q_m = 32'd0;
        endcase
      end
    end
    hit    = (cnt_m == longint'(cmp_m)) && (cmp_m != 32'd0);
    cnt_wr = w && io && (off == 2);
    st_wr  = w && io && (off == 4);
    nxt    = (cnt_m + 1) % 64'h1_0000_0000;
    if (w && !io) mem_m[int'(a[6:0])] = d;
    if (w && io && off == 0) gpio_m = d;
    if (w && io && off == 3) cmp_m = d;
    irq_m = hit || (irq_m && !(st_wr && d[0]));
    ovf_m = (nxt == 0 && !cnt_wr) || (ovf_m && !(st_wr && d[1]));
    cnt_m = cnt_wr ? 0 : nxt;
    hist_m.push_back(gin);
    void'(hist_m.pop_front());
  endtask

  // One bus cycle: drive at the falling edge, clock, return at the next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
    wren = w; rden = r; address = a; data = d;
    @(posedge clk);
    model_step(w, r, a, d, gpio_in);
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (q !== 32'd0) begin bad++; $display("FAIL reset_q got=%h exp=%h", q, 32'd0); end
    total++; if (gpio_out !== 32'd0) begin bad++; $display("FAIL reset_gpio_out got=%h exp=%h", gpio_out, 32'd0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ram_roundtrip();
    cycle(1'b1, 1'b0, 8'h05, 32'hDEAD_BEEF);
    total++; if (q !== 32'd0) begin bad++; $display("FAIL ram_q_before_read got=%h exp=%h", q, 32'd0); end
    cycle(1'b0, 1'b1, 8'h05, 32'd0);
    total++; if (q !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_roundtrip got=%h exp=%h", q, 32'hDEAD_BEEF); end
  endtask

  task automatic test_read_during_write();
    cycle(1'b1, 1'b0, 8'h05, 32'h1111_1111);
    cycle(1'b1, 1'b1, 8'h05, 32'h2222_2222);
    total++; if (q !== 32'h1111_1111) begin bad++; $display("FAIL rdw_old got=%h exp=%h", q, 32'h1111_1111); end
    cycle(1'b0, 1'b1, 8'h05, 32'd0);
    total++; if (q !== 32'h2222_2222) begin bad++; $display("FAIL rdw_new got=%h exp=%h", q, 32'h2222_2222); end
  endtask

  task automatic test_gpio();
    cycle(1'b1, 1'b0, 8'h80, 32'h0000_00A5);
    total++; if (gpio_out !== 32'h0000_00A5) begin bad++; $display("FAIL gpio_out got=%h exp=%h", gpio_out, 32'hA5); end
    gpio_in = 32'h0000_003C;
    for (int e = 1; e <= 3; e++) begin
      cycle(1'b0, 1'b1, 8'h81, 32'd0);
      total++;
      if (q !== ((e == 3) ? 32'h3C : 32'h0)) begin
        bad++; $display("FAIL gpio_in_sync edge=%0d got=%h exp=%h", e, q, (e == 3) ? 32'h3C : 32'h0);
      end
    end
  endtask

  task automatic test_count_compare();
    cycle(1'b1, 1'b0, 8'h82, 32'd0);
    cycle(1'b1, 1'b0, 8'h83, 32'd20);
    cycle(1'b1, 1'b0, 8'h82, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b0, 8'h00, 32'd0);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early edge=%0d got=%b exp=0", k, irq); end
    end
    cycle(1'b0, 1'b0, 8'h00, 32'd0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
    cycle(1'b1, 1'b0, 8'h84, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
    cycle(1'b1, 1'b0, 8'h82, 32'd0);
    for (int k = 1; k <= 20; k++) cycle(1'b0, 1'b0, 8'h00, 32'd0);
    cycle(1'b1, 1'b0, 8'h84, 32'h1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
    cycle(1'b0, 1'b0, 8'h00, 32'd0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_sticky got=%b exp=1", irq); end
  endtask

  task automatic test_overflow_unmapped();
    cycle(1'b1, 1'b0, 8'h83, 32'd0);
    cycle(1'b1, 1'b0, 8'h84, 32'h3);
    force dut.count_r = 32'hFFFF_FFFE;
    #1;
    release dut.count_r;
    cnt_m = 64'h0000_0000_FFFF_FFFE;
    cycle(1'b0, 1'b0, 8'h00, 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 32'd0);
    cycle(1'b0, 1'b1, 8'h84, 32'd0);
    total++; if (q !== 32'h2) begin bad++; $display("FAIL status_overflow got=%h exp=%h", q, 32'h2); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovf_no_irq got=%b exp=0", irq); end
    cycle(1'b0, 1'b1, 8'h87, 32'd0);
    total++; if (q !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h exp=%h", q, 32'd0); end
    cycle(1'b1, 1'b0, 8'h87, $urandom);
    total++; if (gpio_out !== 32'hA5) begin bad++; $display("FAIL unmapped_gpio got=%h exp=%h", gpio_out, 32'hA5); end
    cycle(1'b0, 1'b1, 8'h83, 32'd0);
    total++; if (q !== 32'd0) begin bad++; $display("FAIL unmapped_compare got=%h exp=%h", q, 32'd0); end
    cycle(1'b0, 1'b1, 8'h84, 32'd0);
    total++; if (q !== 32'h2) begin bad++; $display("FAIL unmapped_status got=%h exp=%h", q, 32'h2); end
    cycle(1'b0, 1'b1, 8'h80, 32'd0);
    total++; if (q !== 32'hA5) begin bad++; $display("FAIL unmapped_gpio_rd got=%h exp=%h", q, 32'hA5); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] saved;
    cycle(1'b1, 1'b0, 8'h83, 32'd5);
    cycle(1'b1, 1'b0, 8'h82, 32'd0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 8'h00, 32'd0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_pre_irq got=%b exp=1", irq); end
    cycle(1'b1, 1'b0, 8'h80, 32'h5A5A_0F0F);
    cycle(1'b0, 1'b1, 8'h05, 32'd0);
    saved = $urandom | 32'h1;
    cycle(1'b1, 1'b0, 8'h09, saved);
    wren = 1'b1; address = 8'h0A; data = 32'h7777_7777;
    #2;
    rst = 1'b0;
    #1;
    total++; if (q !== 32'd0) begin bad++; $display("FAIL mid_q got=%h exp=%h", q, 32'd0); end
    total++; if (gpio_out !== 32'd0) begin bad++; $display("FAIL mid_gpio_out got=%h exp=%h", gpio_out, 32'd0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", irq); end
    total++; if (dut.count_r !== 32'd0) begin bad++; $display("FAIL mid_count got=%h exp=%h", dut.count_r, 32'd0); end
    wren = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 8'h09, 32'd0);
    total++; if (q !== saved) begin bad++; $display("FAIL mid_ram_kept got=%h exp=%h", q, saved); end
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i), $urandom);
    for (int n = 0; n < 300; n++) begin
      gpio_in = $urandom;
      if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(0, 15));
      else a = {1'b1, 4'($urandom), 3'($urandom)};
      d = $urandom;
      if (a[7] && a[2:0] == 3'd3) d = 32'($urandom_range(0, 40));
      cycle(1'($urandom), 1'($urandom), a, d);
      if (q_known) begin
        total++; if (q !== q_m) begin bad++; $display("FAIL rand_q n=%0d addr=%h got=%h exp=%h", n, a, q, q_m); end
      end
      total++; if (gpio_out !== gpio_m) begin bad++; $display("FAIL rand_gpio_out n=%0d got=%h exp=%h", n, gpio_out, gpio_m); end
      total++; if (irq !== irq_m) begin bad++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, irq_m); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; wren = 1'b0; rden = 1'b0; address = 8'h00; data = 32'd0; gpio_in = 32'd0;
    model_reset();
    test_reset();
    test_ram_roundtrip();
    test_read_during_write();
    test_gpio();
    test_count_compare();
    test_overflow_unmapped();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
